nyan_ram_arbiter: RTL
=====================

# nyan_ram_arbiter

Arbiter and sequencer sharing the single-port Nyan sprite pixel RAM (1024×4, synchronous read, one-cycle read latency) among three users. Users are the VGA scanout reader, a host/UART loader writing pixels, and an optional bulk-clear engine. The block sits between the video timing/pixel pipeline and the RAM instance, driving the RAM's address, data-in and write-enable pins. Video reads always win; loader writes are buffered in a small FIFO and drained in cycles the video port leaves idle.

## Interface

Parameters:
- `ADDR_WIDTH`, 10: RAM address width.
- `DATA_WIDTH`, 4: pixel width.
- `WFIFO_DEPTH`, 4: loader write FIFO entries; must be a power of two, at least 2.

Ports:
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_vid_req`  in  1  video read request for this cycle.
- `i_vid_addr`  in  ADDR_WIDTH  video read address.
- `o_vid_data`  out  DATA_WIDTH  read data; equals `i_ram_dout`.
- `o_vid_valid`  out  1  `o_vid_data` holds the result of the previous cycle's request.
- `i_wr_valid`  in  1  loader write offered.
- `i_wr_addr`  in  ADDR_WIDTH  loader write address.
- `i_wr_data`  in  DATA_WIDTH  loader write data.
- `o_wr_ready`  out  1  loader write accepted when high together with `i_wr_valid`.
- `i_clear`  in  1  single-cycle pulse that starts a bulk fill.
- `i_clear_data`  in  DATA_WIDTH  fill value, sampled on the accepted `i_clear`.
- `o_clear_busy`  out  1  bulk fill in progress.
- `o_ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `o_ram_din`  out  DATA_WIDTH  to RAM `din`.
- `o_ram_we`  out  1  to RAM `write_en`.
- `i_ram_dout`  in  DATA_WIDTH  from RAM `dout`.

## Operation

- Each cycle exactly one RAM slot is granted, in this priority order:
  1. Video read: `o_ram_addr`=`i_vid_addr`, `o_ram_we`=0.
  2. FIFO head write: pop the FIFO; addr and data come from the head entry; `o_ram_we`=1.
  3. Clear write: addr=`clr_cnt`, data=`clr_val`, `o_ram_we`=1.
  4. Idle: `o_ram_we`=0, addr and din hold their last values.
- The RAM port outputs are a combinational mux of the inputs and registered state.
- Write FIFO:
  - Push on `i_wr_valid & o_wr_ready`.
  - `o_wr_ready` = !full & state==IDLE.
  - When full, a pop in the same cycle does not raise ready.
  - Pointers are ADDR-independent; wrap is modulo `WFIFO_DEPTH`; an extra pointer bit distinguishes full from empty.
- Clear FSM states:
  - IDLE: an `i_clear` pulse latches `clr_val` and moves to DRAIN. `i_clear` pulses while not IDLE are ignored.
  - DRAIN: `o_wr_ready`=0. Moves to FILL once the FIFO is empty; `clr_cnt` resets to 0.
  - FILL: `clr_cnt` increments only on cycles with a clear grant. After the write at address 2^ADDR_WIDTH−1, returns to IDLE and `clr_cnt` wraps to 0.
- `o_clear_busy` = state != IDLE.
- Video is never stalled by loader or clear traffic. Sustained `i_vid_req` starves writes indefinitely; the loader sees `o_wr_ready`=0 once the FIFO fills.
- Reset values: FIFO empty, state IDLE, `clr_cnt`=0, `o_vid_valid`=0, `o_wr_ready`=1 (after release), `o_clear_busy`=0, `o_ram_we`=0, `o_ram_addr`=0, `o_ram_din`=0.
- Reset asserted mid-fill or mid-drain aborts immediately. Queued writes are discarded, and RAM contents stay partially written.

## Timing

- Video read latency is 1 cycle: request in cycle N makes `o_vid_valid`=1 in N+1, with `o_vid_data` the RAM contents at `i_vid_addr(N)`.
- `o_vid_valid` is a registered copy of `i_vid_req`; back-to-back requests give one result per cycle.
- Loader write latency: accepted in cycle N, earliest RAM write in N+1, provided the video port is idle then.
- Read-after-write through the FIFO is not forwarded. A video read of an address with a queued write returns the old value.
- Full fill with no video traffic takes 2^ADDR_WIDTH write cycles plus 1 IDLE→DRAIN cycle plus DRAIN time.

## Configuration

- `NYAN_ARB_CLEAR_EN` defined: the clear FSM, `clr_cnt` and `clr_val` are compiled in, as described above.
- Not defined: `i_clear` and `i_clear_data` are ignored. `o_clear_busy` is tied to 0. The state is permanently IDLE, so `o_wr_ready` = !full. The grant order reduces to video, then FIFO.

## Test plan

- Reset, then `i_vid_req`=1 for 8 consecutive cycles, addr 0..7 over a preloaded RAM → `o_vid_valid` high for cycles 1..8, data matches preload, `o_ram_we`=0 throughout.
- Loader pushes 4 writes (addr 5..8, data A..D) while `i_vid_req`=1 → `o_wr_ready` falls after the 4th push. Drop `i_vid_req` → 4 consecutive `o_ram_we` pulses in FIFO order, then ready returns to 1.
- Loader write to addr 0x3FF data 0xF and video read of 0x3FF in the same cycle → read returns the old value; the write lands on the next idle cycle; a later read returns 0xF.
- With the macro, `i_clear` with data 0x3 while 2 writes are queued → DRAIN writes both, then 1024 writes of 0x3 to addresses 0..1023. `o_clear_busy` falls after the 0x3FF write, and a full readback is all 0x3.
- During FILL, `i_vid_req` on alternate cycles → `clr_cnt` advances only on non-video cycles. Assert `i_rst_n`=0 at `clr_cnt`=0x200 → all outputs take reset values asynchronously and the FIFO is empty after release.
- Without the macro, `i_clear` pulse → `o_clear_busy` stays 0, no extra writes, loader accepted normally.

Source files
------------

// File: rtl/nyan_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nyan_ram_arbiter
// Purpose  : Shares the single-port sprite pixel RAM between video scanout,
//            a FIFO-buffered pixel loader and an optional bulk-clear engine
//            (compiled in when NYAN_ARB_CLEAR_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module nyan_ram_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 4,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_vid_req,
    input  logic [ADDR_WIDTH-1:0] i_vid_addr,
    output logic [DATA_WIDTH-1:0] o_vid_data,
    output logic                  o_vid_valid,
    input  logic                  i_wr_valid,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_clear_data,
    output logic                  o_clear_busy,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_din,
    output logic                  o_ram_we,
    input  logic [DATA_WIDTH-1:0] i_ram_dout
);
    localparam int c_PTR_W = $clog2(WFIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

    // Loader write FIFO; the extra pointer MSB separates full from empty.
    logic [ADDR_WIDTH-1:0] r_fifo_addr [WFIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [WFIFO_DEPTH];
    logic [c_PTR_W:0]      r_wptr;
    logic [c_PTR_W:0]      r_rptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr_ready;

    logic                  r_vid_valid;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [DATA_WIDTH-1:0] r_last_din;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_din;
    logic                  w_ram_we;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                     (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
    assign w_push  = i_wr_valid && w_wr_ready;
    assign w_pop   = !i_vid_req && !w_empty;

`ifdef NYAN_ARB_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] c_CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FILL  = 2'd2
    } clr_state_t;

    clr_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_clr_val;
    logic                  w_clr_gnt;

    // Fill only uses slots that neither video nor the FIFO wants.
    assign w_clr_gnt    = (r_state == ST_FILL) && !i_vid_req && w_empty;
    assign w_wr_ready   = !w_full && (r_state == ST_IDLE);
    assign o_clear_busy = (r_state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
            r_clr_val <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear) begin
                        r_clr_val <= i_clear_data;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_clr_cnt <= '0;
                        r_state   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_clr_gnt) begin
                        r_clr_cnt <= r_clr_cnt + c_CNT_ONE;
                        if (r_clr_cnt == '1) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    logic w_unused_clear;

    assign w_unused_clear = ^{i_clear, i_clear_data};
    assign w_wr_ready     = !w_full;
    assign o_clear_busy   = 1'b0;
`endif

    assign o_wr_ready = w_wr_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[c_PTR_W-1:0]] <= i_wr_addr;
            r_fifo_data[r_wptr[c_PTR_W-1:0]] <= i_wr_data;
        end
    end

    // Fixed-priority grant: video, FIFO head, clear; idle holds the bus.
    always_comb begin
        w_ram_addr = r_last_addr;
        w_ram_din  = r_last_din;
        w_ram_we   = 1'b0;
        if (i_vid_req) begin
            w_ram_addr = i_vid_addr;
        end else if (!w_empty) begin
            w_ram_addr = r_fifo_addr[r_rptr[c_PTR_W-1:0]];
            w_ram_din  = r_fifo_data[r_rptr[c_PTR_W-1:0]];
            w_ram_we   = 1'b1;
        end
`ifdef NYAN_ARB_CLEAR_EN
        else if (w_clr_gnt) begin
            w_ram_addr = r_clr_cnt;
            w_ram_din  = r_clr_val;
            w_ram_we   = 1'b1;
        end
`endif
    end

    assign o_ram_addr = w_ram_addr;
    assign o_ram_din  = w_ram_din;
    assign o_ram_we   = w_ram_we;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vid_valid <= 1'b0;
            r_last_addr <= '0;
            r_last_din  <= '0;
        end else begin
            r_vid_valid <= i_vid_req;
            r_last_addr <= w_ram_addr;
            r_last_din  <= w_ram_din;
        end
    end

    assign o_vid_valid = r_vid_valid;
    assign o_vid_data  = i_ram_dout;

endmodule
`default_nettype wire
